// File: rtl/nano_pkg.sv
// Shared definitions for the motor drive sequencer: direction codes, FSM states,
// H-bridge drive patterns and default timing parameters.
package nano_pkg;

   localparam int unsigned PWM_TOP_DEF   = 100000;
   localparam int unsigned DEAD_CYC_DEF  = 1000000;
   localparam int unsigned RAMP_STEP_DEF = 5;

   localparam logic [2:0] DIR_STOP  = 3'b000;
   localparam logic [2:0] DIR_FWD   = 3'b001;
   localparam logic [2:0] DIR_REV   = 3'b010;
   localparam logic [2:0] DIR_LEFT  = 3'b011;
   localparam logic [2:0] DIR_RIGHT = 3'b100;

   localparam logic [3:0] JA_OFF   = 4'b0000;
   localparam logic [3:0] JA_FWD   = 4'b1010;
   localparam logic [3:0] JA_REV   = 4'b0101;
   localparam logic [3:0] JA_LEFT  = 4'b0110;
   localparam logic [3:0] JA_RIGHT = 4'b1001;

   localparam logic [6:0] DUTY_MAX = 7'd100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2,
      ST_DEAD = 2'd3
   } state_e;

   // Unused codes 101..111 collapse onto stop so every comparison sees one stop value.
   function automatic logic [2:0] dir_normalize(input logic [2:0] dir);
      return (dir > DIR_RIGHT) ? DIR_STOP : dir;
   endfunction

   function automatic logic [3:0] ja_pattern(input logic [2:0] dir);
      logic [3:0] pat;
      case (dir)
         DIR_FWD:   pat = JA_FWD;
         DIR_REV:   pat = JA_REV;
         DIR_LEFT:  pat = JA_LEFT;
         DIR_RIGHT: pat = JA_RIGHT;
         default:   pat = JA_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/motor_drive_sequencer_pwm_gen.sv
// Free-running PWM counter with duty compare; the registered output reflects the
// counter value that is current in the same cycle it is presented.
module pwm_gen
   import nano_pkg::*;
#(
   parameter int unsigned PWM_TOP = PWM_TOP_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] duty,
   input  logic       run,
   output logic       pwm_out,
   output logic       period_end
);

   localparam int unsigned CNT_W = $clog2(PWM_TOP + 1);
   localparam int unsigned SCALE = PWM_TOP / 100;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pwm_q, pwm_d;
   logic [31:0]      thresh;

   // duty and run are next-cycle values, so compare against the next count.
   always_comb begin
      period_end = (cnt_q == CNT_W'(PWM_TOP - 1));
      cnt_d      = period_end ? '0 : cnt_q + CNT_W'(1);
      thresh     = 32'(duty) * SCALE;
      pwm_d      = run && (32'(cnt_d) < thresh);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement or process order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// H-bridge motor sequencer: soft-start ramp, run, and enforced dead-time on any
// direction change or emergency stop. All outputs are registered.
module motor_drive_sequencer
   import nano_pkg::*;
#(
   parameter int unsigned PWM_TOP   = PWM_TOP_DEF,
   parameter int unsigned DEAD_CYC  = DEAD_CYC_DEF,
   parameter int unsigned RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] cmd_dir,
   input  logic [6:0] cmd_duty,
   input  logic       estop,
   output logic       enableA,
   output logic       enableB,
   output logic       JA1,
   output logic       JA2,
   output logic       JA3,
   output logic       JA4,
   output logic       busy
);

   localparam int unsigned DEAD_W = $clog2(DEAD_CYC + 1);

   state_e            state_q, state_d;
   logic [2:0]        dir_q, dir_d;
   logic [6:0]        duty_q, duty_d;
   logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
   logic [3:0]        ja_q, ja_d;
   logic              busy_q, busy_d;

   logic [2:0]        dir_cmd;
   logic [6:0]        target;
   logic [7:0]        duty_step;
   logic              run_d;
   logic              period_end;
   logic              pwm_out;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      dir_cmd    = dir_normalize(cmd_dir);
      target     = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;
      duty_step  = 8'(duty_q) + 8'(RAMP_STEP);
      state_d    = state_q;
      dir_d      = dir_q;
      duty_d     = duty_q;
      dead_cnt_d = dead_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (!estop && dir_cmd != DIR_STOP) begin
               dir_d   = dir_cmd;
               duty_d  = '0;
               state_d = ST_RAMP;
            end
         end
         ST_RAMP, ST_RUN: begin
            // Stop and direction change win over any duty update in the same cycle.
            if (estop || dir_cmd != dir_q) begin
               state_d    = ST_DEAD;
               dead_cnt_d = DEAD_W'(DEAD_CYC - 1);
            end else if (period_end) begin
               if (state_q == ST_RAMP) begin
                  if (duty_step >= {1'b0, target} || target <= duty_q) begin
                     duty_d  = target;
                     state_d = ST_RUN;
                  end else begin
                     duty_d = duty_step[6:0];
                  end
               end else if (target < duty_q) begin
                  duty_d = target;
               end else if (target > duty_q) begin
                  state_d = ST_RAMP;
               end
            end
         end
         ST_DEAD: begin
            if (dead_cnt_q == '0) begin
               if (!estop && dir_cmd != DIR_STOP) begin
                  dir_d   = dir_cmd;
                  duty_d  = '0;
                  state_d = ST_RAMP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               dead_cnt_d = dead_cnt_q - DEAD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from next-state so they track the state they belong to.
      run_d  = (state_d == ST_RAMP) || (state_d == ST_RUN);
      ja_d   = run_d ? ja_pattern(dir_d) : JA_OFF;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_STOP;
         duty_q     <= '0;
         dead_cnt_q <= '0;
         ja_q       <= JA_OFF;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         duty_q     <= duty_d;
         dead_cnt_q <= dead_cnt_d;
         ja_q       <= ja_d;
         busy_q     <= busy_d;
      end
   end

   pwm_gen #(
      .PWM_TOP (PWM_TOP)
   ) u_pwm_gen (
      .clock      (clock),
      .reset      (reset),
      .duty       (duty_d),
      .run        (run_d),
      .pwm_out    (pwm_out),
      .period_end (period_end)
   );

   assign enableA = pwm_out;
   assign enableB = pwm_out;
   assign JA1     = ja_q[3];
   assign JA2     = ja_q[2];
   assign JA3     = ja_q[1];
   assign JA4     = ja_q[0];
   assign busy    = busy_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer with short PWM period and dead-time.
module tb_motor_drive_sequencer;

   localparam int unsigned PWM_TOP   = 100;
   localparam int unsigned DEAD_CYC  = 20;
   localparam int unsigned RAMP_STEP = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] cmd_dir = 3'b001;
   logic [6:0] cmd_duty = 7'd50;
   logic       estop = 1'b0;
   logic       enableA, enableB, JA1, JA2, JA3, JA4, busy;
   logic [3:0] ja_bus;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   assign ja_bus = {JA1, JA2, JA3, JA4};

   motor_drive_sequencer #(
      .PWM_TOP   (PWM_TOP),
      .DEAD_CYC  (DEAD_CYC),
      .RAMP_STEP (RAMP_STEP)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .cmd_dir  (cmd_dir),
      .cmd_duty (cmd_duty),
      .estop    (estop),
      .enableA  (enableA),
      .enableB  (enableB),
      .JA1      (JA1),
      .JA2      (JA2),
      .JA3      (JA3),
      .JA4      (JA4),
      .busy     (busy)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_high();
      int guard;
      guard = 0;
      while (enableA !== 1'b1 && guard < 300) begin
         step();
         guard++;
      end
      check("wait_high_timeout", int'(guard >= 300), 0);
   endtask

   // Length of the next complete enable pulse; -1 if no pulse appears.
   task automatic measure_pulse(output int len);
      int guard;
      guard = 0;
      while (enableA === 1'b1 && guard < 300) begin
         step();
         guard++;
      end
      while (enableA !== 1'b1 && guard < 600) begin
         step();
         guard++;
      end
      len = 0;
      while (enableA === 1'b1 && len < 300) begin
         step();
         len++;
      end
      if (guard >= 600) len = -1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, cnt, acc;

      // Reset held with an active command: nothing may move.
      repeat (3) step();
      check("rst_enableA", int'(enableA), 0);
      check("rst_enableB", int'(enableB), 0);
      check("rst_ja", int'(ja_bus), 0);
      check("rst_busy", int'(busy), 0);

      cmd_dir = 3'b000;
      reset   = 1'b1;
      acc = 0;
      repeat (5) begin
         step();
         acc += int'(busy) + int'(ja_bus != 4'b0000);
      end
      check("idle_stop_stays", acc, 0);

      cmd_dir = 3'b101;
      acc = 0;
      repeat (5) begin
         step();
         acc += int'(busy);
      end
      check("idle_code101_is_stop", acc, 0);

      // Soft-start forward to 50 %.
      cmd_dir  = 3'b001;
      cmd_duty = 7'd50;
      step();
      check("start_ja_fwd", int'(ja_bus), 4'b1010);
      check("start_busy", int'(busy), 1);
      for (int i = 1; i <= 5; i++) begin
         measure_pulse(len);
         check($sformatf("ramp_fwd_%0d", i), len, i * 10);
      end
      cnt = 0;
      while (enableA !== 1'b1 && cnt < 300) begin
         step();
         cnt++;
      end
      check("run50_low", cnt, 50);
      measure_pulse(len);
      check("run50_high", len, 50);

      // Reversal mid-pulse: full dead-time then a fresh ramp.
      wait_high();
      repeat (3) step();
      check("pre_rev_enable", int'(enableA), 1);
      cmd_dir = 3'b010;
      step();
      check("rev_enableA_off", int'(enableA), 0);
      check("rev_enableB_off", int'(enableB), 0);
      check("rev_busy", int'(busy), 1);
      cnt = 0;
      acc = 0;
      while (ja_bus == 4'b0000 && cnt < 100) begin
         acc += int'(enableA) + int'(enableB);
         step();
         cnt++;
      end
      check("rev_dead_len", cnt, 20);
      check("rev_dead_enables", acc, 0);
      check("rev_ja", int'(ja_bus), 4'b0101);
      for (int i = 1; i <= 5; i++) begin
         measure_pulse(len);
         check($sformatf("ramp_rev_%0d", i), len, i * 10);
      end

      // Emergency stop from RUN.
      wait_high();
      repeat (3) step();
      estop = 1'b1;
      step();
      check("estop_enable_off", int'(enableA), 0);
      check("estop_ja_off", int'(ja_bus), 0);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         step();
         cnt++;
      end
      check("estop_dead_len", cnt, 20);
      acc = 0;
      repeat (10) begin
         step();
         acc += int'(busy);
      end
      check("estop_hold_idle", acc, 0);
      estop    = 1'b0;
      cmd_dir  = 3'b001;
      cmd_duty = 7'd127;
      step();
      check("estop_release_busy", int'(busy), 1);
      check("estop_release_ja", int'(ja_bus), 4'b1010);

      // Clamp: 127 ramps to 100 then stays on.
      for (int i = 1; i <= 9; i++) begin
         measure_pulse(len);
         check($sformatf("ramp_clamp_%0d", i), len, i * 10);
      end
      wait_high();
      acc = 0;
      repeat (250) begin
         acc += int'(enableA) + int'(enableB);
         step();
      end
      check("clamp_full_on", acc, 500);

      // Zero duty in RUN: drops at the next period boundary only.
      cmd_duty = 7'd0;
      cnt = 0;
      while (enableA === 1'b1 && cnt < 300) begin
         step();
         cnt++;
      end
      check("zero_tail_high", cnt, 50);
      acc = 0;
      repeat (150) begin
         acc += int'(enableA);
         step();
      end
      check("zero_enable_off", acc, 0);
      check("zero_busy", int'(busy), 1);
      check("zero_ja", int'(ja_bus), 4'b1010);

      // Reset in the middle of a 30 % ramp period.
      cmd_dir = 3'b000;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         step();
         cnt++;
      end
      check("stop_to_idle", int'(busy), 0);
      cmd_dir  = 3'b001;
      cmd_duty = 7'd50;
      step();
      for (int i = 1; i <= 2; i++) begin
         measure_pulse(len);
         check($sformatf("ramp_pre_rst_%0d", i), len, i * 10);
      end
      wait_high();
      repeat (5) step();
      check("pre_rst_enable", int'(enableA), 1);
      reset = 1'b0;
      #1;
      check("midrst_enable", int'(enableA), 0);
      check("midrst_ja", int'(ja_bus), 0);
      check("midrst_busy", int'(busy), 0);
      step();
      step();
      reset = 1'b1;
      step();
      check("post_rst_busy", int'(busy), 1);
      check("post_rst_ja", int'(ja_bus), 4'b1010);
      measure_pulse(len);
      check("post_rst_ramp", len, 10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
